// File: rtl/grid_game_core_pkg.sv
// Shared definitions for the hazard/gold grid game engine: state encodings,
// LFSR feedback polynomial and the widths seen by the display controller.
package grid_game_core_pkg;

    // Game phase as presented on game_state
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } game_state_t;

    // Right-shift Galois feedback mask for x^32 + x^22 + x^2 + x + 1
    // (taps 32, 22, 2, 1 map to bits 31, 21, 1, 0).
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    // Display-facing widths
    localparam int GAME_STATE_W = 2;
    localparam int LIFE_W       = 3;

endpackage

// File: rtl/grid_game_core_lfsr32.sv
// 32-bit Galois LFSR that advances only when en is high.
module lfsr32
    import grid_game_core_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_2025
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [31:0] q
);

    // Shift right; when the bit falling out is 1, fold in the feedback mask.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= SEED;
        end else if (en) begin
            q <= {1'b0, q[31:1]} ^ (q[0] ? LFSR_POLY : 32'h0);
        end
    end

endmodule

// File: rtl/grid_game_core.sv
// Game engine for the hazard/gold grid: owns the game FSM, round timing,
// fire/gold pattern generation, score/life bookkeeping and win/lose.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | waiting for start; grid dark, score 0, full lives
//   ST_PLAY | rounds running; evaluated on every ROUND_TICKS-th tick
//   ST_OVER | game finished; score/life/win hold until the next start
module grid_game_core
    import grid_game_core_pkg::*;
#(
    parameter int          CELLS       = 9,
    parameter int          LIVES       = 3,
    parameter int          SCORE_W     = 4,
    parameter int          WIN_SCORE   = 10,
    parameter int          ROUND_TICKS = 4,
    parameter int          SUPER_USES  = 2,
    parameter logic [31:0] SEED        = 32'hACE1_2025
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic                    start,
    input  logic                    super_req,
    input  logic [CELLS-1:0]        box,
    output logic [GAME_STATE_W-1:0] game_state,
    output logic [SCORE_W-1:0]      score,
    output logic [LIFE_W-1:0]       life,
    output logic [CELLS-1:0]        fire_state,
    output logic [CELLS-1:0]        gold_state,
    output logic [CELLS-1:0]        next_fire_pattern,
    output logic                    win
);

    localparam int CNT_W  = (ROUND_TICKS > 2) ? $clog2(ROUND_TICKS) : 1;
    localparam int CRED_W = (SUPER_USES > 0) ? $clog2(SUPER_USES + 1) : 1;

    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
    localparam logic [LIFE_W-1:0]  LIFE_INIT = LIFE_W'(LIVES);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(ROUND_TICKS - 1);
    localparam logic [CRED_W-1:0]  CRED_INIT = CRED_W'(SUPER_USES);

    game_state_t       state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CRED_W-1:0] cred_q;
    logic [31:0]       lfsr_q;

    logic [CELLS-1:0]  fire_load;
    logic [CELLS-1:0]  gold_onehot;
    logic [CELLS-1:0]  gold_load;
    logic [7:0]        gold_idx;

    logic              hit;
    logic              shield;
    logic [LIFE_W-1:0] life_eval;
    logic [SCORE_W-1:0] score_eval;
    logic [CRED_W-1:0] cred_eval;

    // Not every LFSR bit feeds the grid for small CELLS.
    logic              lfsr_unused;

    lfsr32 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (tick),
        .q   (lfsr_q)
    );

    assign lfsr_unused       = ^lfsr_q;
    assign game_state        = state_q;
    assign next_fire_pattern = fire_load;

    // Grid reload candidate from the current (pre-advance) LFSR value; the
    // gold cell is suppressed when it would land on a burning cell.
    always_comb begin
        fire_load   = lfsr_q[CELLS-1:0] & lfsr_q[CELLS+15:16];
        gold_idx    = lfsr_q[31:24] % 8'(CELLS);
        gold_onehot = '0;
        for (int i = 0; i < CELLS; i++) begin
            gold_onehot[i] = (gold_idx == 8'(i));
        end
        gold_load = (|(gold_onehot & fire_load)) ? '0 : gold_onehot;
    end

    // Round evaluation: hit/shield decision and the resulting life, score
    // and credit values, applied only on the evaluating tick.
    always_comb begin
        hit        = |(box & fire_state);
        shield     = hit & super_req & (cred_q != '0);
        life_eval  = (hit && !shield) ? (life - LIFE_W'(1)) : life;
        cred_eval  = shield ? (cred_q - CRED_W'(1)) : cred_q;
        score_eval = ((|(box & gold_state)) && (score != SCORE_MAX))
                     ? (score + SCORE_W'(1)) : score;
    end

    // Game FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            score      <= '0;
            life       <= LIFE_INIT;
            fire_state <= '0;
            gold_state <= '0;
            win        <= 1'b0;
            cnt_q      <= '0;
            cred_q     <= CRED_INIT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q    <= ST_PLAY;
                        score      <= '0;
                        life       <= LIFE_INIT;
                        cred_q     <= CRED_INIT;
                        cnt_q      <= '0;
                        fire_state <= fire_load;
                        gold_state <= gold_load;
                    end
                end
                ST_PLAY: begin
                    if (tick) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q  <= '0;
                            score  <= score_eval;
                            life   <= life_eval;
                            cred_q <= cred_eval;
                            // Running out of lives beats reaching the target.
                            if (life_eval == '0) begin
                                state_q    <= ST_OVER;
                                win        <= 1'b0;
                                fire_state <= '0;
                                gold_state <= '0;
                            end else if (score_eval >= WIN_VAL) begin
                                state_q    <= ST_OVER;
                                win        <= 1'b1;
                                fire_state <= '0;
                                gold_state <= '0;
                            end else begin
                                fire_state <= fire_load;
                                gold_state <= gold_load;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_OVER: begin
                    if (start) begin
                        state_q    <= ST_IDLE;
                        win        <= 1'b0;
                        score      <= '0;
                        life       <= LIFE_INIT;
                        fire_state <= '0;
                        gold_state <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grid_game_core.sv
// Self-checking bench for grid_game_core: directed game scenarios plus a
// random phase, all compared each cycle against a behavioural game model.
module tb_grid_game_core;

    localparam int          CELLS       = 9;
    localparam int          LIVES       = 3;
    localparam int          SCORE_W     = 4;
    localparam int          WIN_SCORE   = 10;
    localparam int          ROUND_TICKS = 4;
    localparam int          SUPER_USES  = 2;
    localparam logic [31:0] SEED        = 32'hACE1_2025;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               tick = 1'b0;
    logic               start = 1'b0;
    logic               super_req = 1'b0;
    logic [CELLS-1:0]   box = '0;
    logic [1:0]         game_state;
    logic [SCORE_W-1:0] score;
    logic [2:0]         life;
    logic [CELLS-1:0]   fire_state;
    logic [CELLS-1:0]   gold_state;
    logic [CELLS-1:0]   next_fire_pattern;
    logic               win;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    logic [31:0]      m_lfsr;
    int               m_state;
    int               m_score;
    int               m_life;
    int               m_cred;
    int               m_cnt;
    int               m_win;
    logic [CELLS-1:0] m_fire;
    logic [CELLS-1:0] m_gold;

    grid_game_core #(
        .CELLS       (CELLS),
        .LIVES       (LIVES),
        .SCORE_W     (SCORE_W),
        .WIN_SCORE   (WIN_SCORE),
        .ROUND_TICKS (ROUND_TICKS),
        .SUPER_USES  (SUPER_USES),
        .SEED        (SEED)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .tick              (tick),
        .start             (start),
        .super_req         (super_req),
        .box               (box),
        .game_state        (game_state),
        .score             (score),
        .life              (life),
        .fire_state        (fire_state),
        .gold_state        (gold_state),
        .next_fire_pattern (next_fire_pattern),
        .win               (win)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return (l >> 1) ^ (((l & 32'd1) != 0) ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic logic [CELLS-1:0] f_fire(input logic [31:0] l);
        logic [31:0] mask = (32'd1 << CELLS) - 32'd1;
        return CELLS'(l & mask) & CELLS'((l >> 16) & mask);
    endfunction

    function automatic logic [CELLS-1:0] f_gold(input logic [31:0] l);
        logic [CELLS-1:0] f = f_fire(l);
        int g = int'(l >> 24) % CELLS;
        if (((f >> g) & 1) != 0) return '0;
        return CELLS'(1) << g;
    endfunction

    task automatic m_reset();
        m_lfsr  = SEED;
        m_state = 0;
        m_score = 0;
        m_life  = LIVES;
        m_cred  = SUPER_USES;
        m_cnt   = 0;
        m_win   = 0;
        m_fire  = '0;
        m_gold  = '0;
    endtask

    // One rising edge of the game rules, using the inputs currently applied.
    task automatic model_step();
        logic [31:0] pre = m_lfsr;
        if (tick) m_lfsr = lfsr_step(m_lfsr);
        case (m_state)
            0: if (start) begin
                m_state = 1;
                m_score = 0;
                m_life  = LIVES;
                m_cred  = SUPER_USES;
                m_cnt   = 0;
                m_fire  = f_fire(pre);
                m_gold  = f_gold(pre);
            end
            1: if (tick) begin
                if (m_cnt == ROUND_TICKS - 1) begin
                    m_cnt = 0;
                    if ((box & m_fire) != 0) begin
                        if (super_req && m_cred > 0) m_cred--;
                        else m_life--;
                    end
                    if ((box & m_gold) != 0 && m_score < (1 << SCORE_W) - 1) m_score++;
                    m_fire = f_fire(pre);
                    m_gold = f_gold(pre);
                    if (m_life == 0) begin
                        m_state = 2; m_win = 0; m_fire = '0; m_gold = '0;
                    end else if (m_score >= WIN_SCORE) begin
                        m_state = 2; m_win = 1; m_fire = '0; m_gold = '0;
                    end
                end else begin
                    m_cnt++;
                end
            end
            default: if (start) begin
                m_state = 0; m_win = 0; m_score = 0; m_life = LIVES;
            end
        endcase
    endtask

    task automatic compare_all();
        chk("game_state", 32'(game_state), 32'(m_state));
        chk("score", 32'(score), 32'(m_score));
        chk("life", 32'(life), 32'(m_life));
        chk("fire_state", 32'(fire_state), 32'(m_fire));
        chk("gold_state", 32'(gold_state), 32'(m_gold));
        chk("next_fire_pattern", 32'(next_fire_pattern), 32'(f_fire(m_lfsr)));
        chk("win", 32'(win), 32'(m_win));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic pulse_start(input logic with_tick);
        start = 1'b1;
        tick  = with_tick;
        cycle();
        start = 1'b0;
        tick  = 1'b0;
    endtask

    // Run one round; box/super wander randomly except on the evaluating tick.
    task automatic play_round(input logic [CELLS-1:0] final_box, input logic sup);
        int  guard = 0;
        bit  done  = 0;
        while (!done && guard < 4 * ROUND_TICKS) begin
            guard++;
            repeat ($urandom_range(0, 2)) begin
                tick = 1'b0; box = CELLS'($urandom); super_req = 1'($urandom);
                cycle();
            end
            if (m_cnt == ROUND_TICKS - 1) begin
                box = final_box; super_req = sup; done = 1;
            end else begin
                box = CELLS'($urandom); super_req = 1'($urandom);
            end
            tick = 1'b1;
            cycle();
            tick = 1'b0;
        end
        if (!done) chk("round_evaluated", 32'(done), 32'd1);
    endtask

    initial begin
        int hits;
        int rounds;

        // Reset values
        m_reset();
        @(negedge clk);
        chk("rst_game_state", 32'(game_state), 32'd0);
        chk("rst_life", 32'(life), 32'd3);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_fire", 32'(fire_state), 32'd0);
        chk("rst_win", 32'(win), 32'd0);
        chk("rst_nfp", 32'(next_fire_pattern), 32'(f_fire(SEED)));
        rst = 1'b1;
        cycle();

        // Start, then a round with nothing covered
        pulse_start(1'b0);
        chk("play_entry", 32'(game_state), 32'd1);
        play_round('0, 1'b0);
        chk("empty_round_score", 32'(score), 32'd0);
        chk("empty_round_life", 32'(life), 32'd3);

        // Super immunity: two shielded hit rounds, then the third costs a life
        hits = 0; rounds = 0;
        while (hits < 3 && rounds < 100 && m_state == 1) begin
            rounds++;
            if (m_fire != 0) begin
                play_round(m_fire, 1'b1);
                hits++;
                if (hits < 3) chk("super_life_held", 32'(life), 32'd3);
                else chk("super_exhausted", 32'(life), 32'd2);
            end else begin
                play_round('0, 1'b1);
            end
        end
        if (hits < 3) chk("super_hits_reached", 32'(hits), 32'd3);

        // Keep hitting fire without super until the game is lost
        rounds = 0;
        while (m_state == 1 && rounds < 200) begin
            rounds++;
            play_round(m_fire, 1'b0);
        end
        chk("lose_state", 32'(game_state), 32'd2);
        chk("lose_win", 32'(win), 32'd0);
        chk("lose_life", 32'(life), 32'd0);

        // OVER ignores ticks
        repeat (6) begin
            tick = 1'b1; cycle();
            tick = 1'b0; cycle();
        end
        chk("over_hold_state", 32'(game_state), 32'd2);

        pulse_start(1'b0);
        chk("restart_idle", 32'(game_state), 32'd0);
        chk("restart_life", 32'(life), 32'd3);

        // Start coinciding with a tick, then collect gold until the win
        pulse_start(1'b1);
        rounds = 0;
        while (m_state == 1 && rounds < 300) begin
            rounds++;
            play_round(m_gold, 1'b0);
        end
        chk("win_state", 32'(game_state), 32'd2);
        chk("win_flag", 32'(win), 32'd1);
        chk("win_score", 32'(score), 32'd10);
        repeat (8) begin
            tick = 1'b1; cycle();
            tick = 1'b0; cycle();
        end
        chk("win_hold_score", 32'(score), 32'd10);
        chk("win_hold_flag", 32'(win), 32'd1);

        // Score 9, life 1, then hit and gold together: loss takes priority
        pulse_start(1'b0);
        pulse_start(1'b0);
        rounds = 0;
        while (m_state == 1 && rounds < 400) begin
            rounds++;
            if (m_score < WIN_SCORE - 1) play_round(m_gold, 1'b0);
            else if (m_life > 1) play_round(m_fire, 1'b0);
            else if (m_fire != 0 && m_gold != 0) play_round(m_fire | m_gold, 1'b0);
            else play_round('0, 1'b0);
        end
        chk("tie_state", 32'(game_state), 32'd2);
        chk("tie_win", 32'(win), 32'd0);
        chk("tie_score", 32'(score), 32'd10);
        chk("tie_life", 32'(life), 32'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            start     = ($urandom_range(0, 15) == 0);
            tick      = ($urandom_range(0, 2) == 0);
            super_req = 1'($urandom);
            box       = CELLS'($urandom);
            cycle();
        end
        start = 1'b0; tick = 1'b0;

        // Asynchronous reset in the middle of a game
        if (m_state == 2) pulse_start(1'b0);
        if (m_state == 0) pulse_start(1'b0);
        while (m_cnt < ROUND_TICKS - 2) begin
            tick = 1'b1; cycle(); tick = 1'b0;
        end
        chk("pre_reset_play", 32'(game_state), 32'd1);
        #2 rst = 1'b0;
        #1;
        m_reset();
        chk("arst_game_state", 32'(game_state), 32'd0);
        chk("arst_score", 32'(score), 32'd0);
        chk("arst_life", 32'(life), 32'd3);
        chk("arst_fire", 32'(fire_state), 32'd0);
        chk("arst_gold", 32'(gold_state), 32'd0);
        chk("arst_win", 32'(win), 32'd0);
        chk("arst_nfp", 32'(next_fire_pattern), 32'(f_fire(SEED)));
        @(negedge clk);
        rst = 1'b1;
        tick = 1'b1; cycle(); tick = 1'b0;
        pulse_start(1'b0);
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
